// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle add/sub/logic/shift/compare ops, iterative MULU/DIVU.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for MULU/DIVU.
// Backpressure: in_ready is high only in IDLE; requests made while busy are dropped, not queued.
//
// Optional feature: define ALU_MC_DIV_EN to compile in the restoring divider (DIVU).
// Without it, DIVU completes in one cycle with result=0, hi=0, overflow=1.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake; op, inA, inB latched at accept
//   out_valid         one-cycle pulse qualifying result/hi/cond_code
//   result, hi        primary result, high product / remainder (held until next completion)
//   cond_code         {eq, ne, lt, gt, zero, overflow}
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [5:0]       cond_code
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b0110;
  localparam logic [3:0] OP_DIVU = 4'b1000;

  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] a_q, b_q;
  // Shared iteration register: {p_hi, p_lo} is the product-in-progress for MULU
  // and {remainder, dividend/quotient} for DIVU.
  logic [WIDTH-1:0] p_hi, p_lo;

  assign in_ready = (state == S_IDLE);

  function automatic logic [5:0] flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [WIDTH-1:0] r, input logic ov);
    logic eq;
    eq = (a == b);
    return {eq, !eq, $signed(a) < $signed(b), $signed(a) > $signed(b), r == '0, ov};
  endfunction

  // Single-cycle results, computed straight from the inputs in the accept cycle.
  logic [WIDTH-1:0] add_s, sub_s, sc_res, sc_hi;
  logic             sc_ov;

  assign add_s = inA + inB;
  assign sub_s = inA - inB;

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ov  = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_s;
        sc_ov  = (inA[WIDTH-1] == inB[WIDTH-1]) && (add_s[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_s;
        sc_ov  = (inA[WIDTH-1] != inB[WIDTH-1]) && (sub_s[WIDTH-1] != inA[WIDTH-1]);
      end
      OP_AND:  sc_res = inA & inB;
      OP_OR:   sc_res = inA | inB;
      OP_SLL:  sc_res = inA << inB[SHW-1:0];
      OP_SRL:  sc_res = inA >> inB[SHW-1:0];
      OP_LUI:  sc_res = inB << (WIDTH / 2);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(inA) < $signed(inB)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, inA < inB};
`ifdef ALU_MC_DIV_EN
      // Only reaches the output when the divisor is zero; otherwise DIV takes over.
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = inA;
        sc_ov  = 1'b1;
      end
`else
      OP_DIVU: sc_ov = 1'b1;
`endif
      default: ;
    endcase
  end

  // Shift-add multiplier step: add multiplicand into the top half when the
  // current multiplier bit is set, then shift the whole double word right.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], p_lo[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  // Restoring divider step: shift in the next dividend bit, subtract the
  // divisor if it fits; the quotient bit enters at the bottom of p_lo.
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

  assign div_sh    = {p_hi, p_lo[WIDTH-1]};
  assign div_diff  = div_sh - {1'b0, b_q};
  assign div_ge    = (div_sh >= {1'b0, b_q});
  assign div_hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_nx = {p_lo[WIDTH-2:0], div_ge};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      result    <= '0;
      hi        <= '0;
      cond_code <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= inA;
            b_q <= inB;
            cnt <= CNT_INIT;
            if (op == OP_MULU) begin
              p_hi  <= '0;
              p_lo  <= inB;
              state <= S_MUL;
            end
`ifdef ALU_MC_DIV_EN
            else if (op == OP_DIVU && inB != '0) begin
              p_hi  <= '0;
              p_lo  <= inA;
              state <= S_DIV;
            end
`endif
            else begin
              result    <= sc_res;
              hi        <= sc_hi;
              cond_code <= flags(inA, inB, sc_res, sc_ov);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          p_hi <= mul_hi_nx;
          p_lo <= mul_lo_nx;
          if (cnt == '0) begin
            result    <= mul_lo_nx;
            hi        <= mul_hi_nx;
            cond_code <= flags(a_q, b_q, mul_lo_nx, mul_hi_nx != '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
`ifdef ALU_MC_DIV_EN
        S_DIV: begin
          p_hi <= div_hi_nx;
          p_lo <= div_lo_nx;
          if (cnt == '0) begin
            result    <= div_lo_nx;
            hi        <= div_hi_nx;
            cond_code <= flags(a_q, b_q, div_lo_nx, 1'b0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed vectors, scoreboard queue checked by a monitor on out_valid.
module tb_alu_mc;

  localparam logic [3:0] ADD  = 4'b0001;
  localparam logic [3:0] SUB  = 4'b1001;
  localparam logic [3:0] AND_ = 4'b0011;
  localparam logic [3:0] OR_  = 4'b0100;
  localparam logic [3:0] SLL  = 4'b0101;
  localparam logic [3:0] SRL  = 4'b1101;
  localparam logic [3:0] LUI  = 4'b0111;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b1010;
  localparam logic [3:0] MULU = 4'b0110;
  localparam logic [3:0] DIVU = 4'b1000;
  localparam logic [3:0] BAD  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] inA = 32'd0, inB = 32'd0;
  logic        out_valid;
  logic [31:0] result, hi;
  logic [5:0]  cond_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] h;
    logic [5:0]  c;
  } exp_t;
  exp_t sb_q[$];

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .inA(inA), .inB(inB), .out_valid(out_valid), .result(result), .hi(hi),
    .cond_code(cond_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every completion.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        check("ready_and_valid", {63'd0, in_ready}, 64'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", {32'd0, result}, {32'd0, e.r});
          check("hi", {32'd0, hi}, {32'd0, e.h});
          check("cond_code", {58'd0, cond_code}, {58'd0, e.c});
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  // Issue one op from a negedge, scoreboard the response, check latency and hold.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eh, input logic [5:0] ec,
                       input int elat);
    bit ok;
    int n;
    exp_t e;
    wait_ready(ok);
    if (!ok) return;
    op = o; inA = a; inB = b; in_valid = 1'b1;
    e.r = er; e.h = eh; e.c = ec;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inA = $urandom;
    inB = $urandom;
    op  = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    check("latency", 64'(n), 64'(elat));
    @(negedge clk);
    check("pulse_width", {63'd0, out_valid}, 64'd0);
    check("result_hold", {32'd0, result}, {32'd0, er});
  endtask

  initial begin
    bit ok;
    int t;
    exp_t e;

    #1 rst = 1'b1;
    #7;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_cc", {58'd0, cond_code}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // cond_code = {eq, ne, lt, gt, zero, ov}
    issue(ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'd0, 6'b010101, 1);
    issue(SUB,  32'd5,         32'd5,         32'd0,         32'd0, 6'b100010, 1);
    issue(SUB,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 32'd0, 6'b011001, 1);
    issue(AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'd0, 6'b011000, 1);
    issue(OR_,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'd0, 6'b010100, 1);
    issue(SLL,  32'd3,         32'hFFFF_FF21, 32'd6,         32'd0, 6'b010100, 1);
    issue(SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 32'd0, 6'b011000, 1);
    issue(LUI,  32'd0,         32'h0000_ABCD, 32'hABCD_0000, 32'd0, 6'b011000, 1);
    issue(SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         32'd0, 6'b011000, 1);
    issue(SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0, 6'b011010, 1);
    issue(BAD,  32'd7,         32'd7,         32'd0,         32'd0, 6'b100010, 1);
    issue(MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 6'b100001, 33);
    issue(MULU, 32'd3,         32'd5,         32'd15,        32'd0, 6'b011000, 33);
    issue(MULU, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1, 6'b100011, 33);
`ifdef ALU_MC_DIV_EN
    issue(DIVU, 32'd100,       32'd7,         32'd14,        32'd2, 6'b010100, 33);
    issue(DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100, 6'b010101, 1);
    issue(DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF, 6'b011000, 33);
`else
    issue(DIVU, 32'd100,       32'd7,         32'd0,         32'd0, 6'b010111, 1);
    issue(DIVU, 32'd100,       32'd0,         32'd0,         32'd0, 6'b010111, 1);
    issue(DIVU, 32'hFFFF_FFFF, 32'h10,        32'd0,         32'd0, 6'b011011, 1);
`endif

    // Back-pressure: ADD held valid during a MULU; operand changes after accept are ignored.
    wait_ready(ok);
    op = MULU; inA = 32'd3; inB = 32'd5; in_valid = 1'b1;
    e.r = 32'd15; e.h = 32'd0; e.c = 6'b011000;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    op = ADD; inA = 32'd2; inB = 32'd3;
    e.r = 32'd5; e.h = 32'd0; e.c = 6'b011000;
    sb_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    check("bp_busy_cycles", 64'(t), 64'd34);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 50);
    check("bp_add_after_ready", 64'(t), 64'd2);
    repeat (5) @(negedge clk);
    check("bp_queue_drained", 64'(sb_q.size()), 64'd0);

    // Reset in cycle 5 of a MULU: in-flight op discarded, outputs cleared at once.
    wait_ready(ok);
    op = MULU; inA = 32'hFFFF; inB = 32'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mul_busy", {63'd0, in_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_result", {32'd0, result}, 64'd0);
    check("mid_rst_cc", {58'd0, cond_code}, 64'd0);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(SLL, 32'd1, 32'd31, 32'h8000_0000, 32'd0, 6'b011000, 1);

    repeat (40) @(negedge clk);
    check("final_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the 16-bit datapath ALU. Full-width add/sub/logic/shift/compare operations complete in one registered cycle. Iterative unsigned multiply and divide take WIDTH cycles each, under a valid/ready handshake. Sits in the execute stage; the pipeline control stalls on `in_ready` low and captures results on `out_valid`.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request (state IDLE).
- `op`  in  4  operation code.
- `inA`, `inB`  in  WIDTH  operands.
- `out_valid`  out  1  single-cycle pulse; `result`/`hi`/`cond_code` are valid.
- `result`  out  WIDTH  primary result (low product, quotient).
- `hi`  out  WIDTH  high product / remainder; 0 for other ops.
- `cond_code`  out  6  {eq, ne, lt, gt, zero, overflow}.

## Operation
- Opcodes:
  - 0001 ADD; 1001 SUB.
  - 0011 AND; 0100 OR.
  - 0101 SLL and 1101 SRL by `inB[SHW-1:0]`.
  - 0111 LUI: `inB << WIDTH/2`.
  - 0010 SLT (signed); 1010 SLTU: result = {0…, flag}.
  - 0110 MULU; 1000 DIVU.
  - Any other code: result 0, single-cycle.
- Accept = `in_valid && in_ready`. Operands and op are latched at accept; later changes to the inputs have no effect.
- FSM states:
  - IDLE: accepting single-cycle op → DONE; MULU → MUL; DIVU → DIV (or DONE if divisor is 0).
  - MUL: shift-add, one multiplier bit per cycle, counter WIDTH-1 down to 0; → DONE when counter reaches 0.
  - DIV: restoring, one quotient bit per cycle, same counter; → DONE when counter reaches 0.
  - DONE: `out_valid`=1 for exactly one cycle; → IDLE.
- `in_ready` = (state == IDLE). A request while not ready is ignored; it is not queued.
- Arithmetic:
  - ADD/SUB are full WIDTH.
  - overflow = signed overflow for ADD/SUB; for MULU, (`hi` != 0).
  - All other ops: overflow = 0.
- Compare flags are taken from the latched operands for every op:
  - eq = A==B; ne = !eq.
  - lt/gt are signed A<B / A>B.
  - zero = (`result` == 0).
- SLTU result uses an unsigned compare; it does not use the lt flag.
- MULU: {`hi`, `result`} = 2·WIDTH-bit unsigned product.
- DIVU: `result` = quotient, `hi` = remainder.
- Divide by zero: quotient = all ones, remainder = A, overflow = 1; completes without entering DIV.
- Outputs hold their last values after `out_valid` drops, until the next DONE.
- Reset (any time, including mid MUL/DIV):
  - state → IDLE, counter → 0.
  - `result`, `hi`, `cond_code`, `out_valid` → 0; `in_ready` → 1.
  - Any in-flight operation is discarded.

## Timing
- Single-cycle ops: accept at edge N; `out_valid` high in cycle N+1. Next accept is possible at edge N+2.
- MULU/DIVU: accept at N; WIDTH cycles in MUL/DIV; `out_valid` in cycle N+WIDTH+1; `in_ready` is low for WIDTH+1 cycles.
- Divide by zero: same timing as a single-cycle op.
- `out_valid` and `in_ready` are never high in the same cycle.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_MC_DIV_EN`
  - Defined: DIV state and restoring divider are compiled in; DIVU behaves as above.
  - Undefined: DIV logic is absent. DIVU is treated as an unknown code: single-cycle, `result` = 0, `hi` = 0, overflow = 1.

## Test plan
- ADD, WIDTH=16: A=0x7FFF, B=0x0001 → `out_valid` at cycle 1 after accept; result 0x8000; overflow=1, lt=0, gt=1, zero=0.
- SLT / SLTU, WIDTH=32: A=0xFFFFFFFF, B=1:
  - SLT → result 1, lt=1.
  - SLTU → result 0.
- MULU, WIDTH=16: A=0xFFFF, B=0xFFFF → `in_ready` low for 17 cycles; `out_valid` at cycle 17 after accept; result 0x0001, hi 0xFFFE, overflow=1.
- DIVU, WIDTH=32, macro defined:
  - A=100, B=7 → result 14, hi 2 after 33 cycles.
  - B=0 → result 0xFFFFFFFF, hi=100, overflow=1, 1 cycle.
- Back-pressure: hold `in_valid` with an ADD during a MULU → the ADD is not accepted until `in_ready` returns; it completes exactly once, 2 cycles after `in_ready` rises.
- Assert `rst` at cycle 5 of a MULU → immediately state IDLE, outputs 0, `in_ready`=1; a following SLL with A=1, B=31 (WIDTH=32) → result 0x80000000.
